// File: rtl/fifo_burst_reader.sv
// Read-side master for an 8-deep byte FIFO: pops one byte per ren pulse, absorbs the
// registered read latency/error flag, and streams bytes out on a valid/ready port.
module fifo_burst_reader #(
  parameter int DW      = 8,
  parameter int LEN_W   = 4,
  parameter int BACKOFF = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             fifo_ren,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_error,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining,
  output logic             underflow
);

  localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_BACKOFF, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [BW-1:0]    r_bo_cnt;
  logic [DW-1:0]    r_out_data;
  logic             r_out_valid;
  logic [LEN_W-1:0] r_rem;
  logic             r_uf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Strobes are decoded from the async-reset state so they drop with rst_n.
  always_comb begin
    w_next   = r_state;
    fifo_ren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = (len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        fifo_ren = 1'b1;
        busy     = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        busy   = 1'b1;
        w_next = fifo_error ? S_BACKOFF : S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (out_ready) w_next = (r_rem == LEN_W'(1)) ? S_DONE : S_ISSUE;
      end
      S_BACKOFF: begin
        busy = 1'b1;
        if (r_bo_cnt == '0) w_next = S_ISSUE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bo_cnt    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
      r_uf        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_rem <= len;
          r_uf  <= 1'b0;
        end
        // An error means the FIFO was empty: drop its zero byte and retry later.
        S_WAIT: if (fifo_error) begin
          r_uf     <= 1'b1;
          r_bo_cnt <= BW'(BACKOFF - 1);
        end else begin
          r_out_data  <= fifo_dout;
          r_out_valid <= 1'b1;
        end
        S_HOLD: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_rem       <= r_rem - LEN_W'(1);
        end
        S_BACKOFF: if (r_bo_cnt != '0) r_bo_cnt <= r_bo_cnt - BW'(1);
        default: ;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign remaining = r_rem;
  assign underflow = r_uf;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, event-scheduled reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_burst_reader;
  localparam int DW = 8, LEN_W = 4, BACKOFF = 3;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             fifo_ren, fifo_error;
  logic [DW-1:0]    fifo_dout, out_data;
  logic             out_valid, busy, done, underflow;
  logic [LEN_W-1:0] remaining;
  logic             wen = 1'b0;
  logic [DW-1:0]    din = '0;

  int errors = 0, checks = 0;
  int cyc = 0;

  fifo_burst_reader #(.DW(DW), .LEN_W(LEN_W), .BACKOFF(BACKOFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .fifo_ren(fifo_ren), .fifo_dout(fifo_dout), .fifo_error(fifo_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .remaining(remaining), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO environment: registered dout/error, ren wins over wen, empty read flags error.
  logic [DW-1:0] fq[$];
  always begin
    @(posedge clk);
    cyc <= cyc + 1;
    if (fifo_ren) begin
      if (fq.size() == 0) begin
        fifo_dout  <= '0;
        fifo_error <= 1'b1;
      end else begin
        fifo_dout  <= fq.pop_front();
        fifo_error <= 1'b0;
      end
    end else begin
      fifo_error <= 1'b0;
      if (wen && fq.size() < 8) fq.push_back(din);
    end
  end

  // Reference model: schedules the cycle of each expected event from the timing rules.
  logic [DW-1:0] mq[$];
  int ren_at = -1, valid_at = -1, uf_at = -1, done_at = -1, m_rem = 0;
  bit m_busy = 1'b0, m_uf = 1'b0, exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0, pend_data = '0;
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ren_at = -1; valid_at = -1; uf_at = -1; done_at = -1;
      m_rem = 0; m_busy = 1'b0; m_uf = 1'b0; exp_valid = 1'b0;
    end else begin
      int c, n;
      bit hs, idle;
      c    = cyc;
      n    = c + 1;
      hs   = exp_valid && out_ready;
      idle = !m_busy && (done_at != c);
      if (c == ren_at) begin
        if (mq.size() == 0) begin
          uf_at  = c + 2;
          ren_at = c + BACKOFF + 2;
        end else begin
          pend_data = mq.pop_front();
          valid_at  = c + 2;
        end
      end else if (wen && mq.size() < 8) mq.push_back(din);
      if (idle && start) begin
        m_uf  = 1'b0;
        m_rem = int'(len);
        if (len == '0) done_at = n;
        else begin
          m_busy = 1'b1;
          ren_at = n;
        end
      end
      if (hs) begin
        exp_valid = 1'b0;
        m_rem--;
        if (m_rem == 0) begin
          m_busy  = 1'b0;
          done_at = n;
        end else ren_at = n;
      end
      if (n == uf_at) m_uf = 1'b1;
      if (n == valid_at) begin
        exp_valid = 1'b1;
        exp_data  = pend_data;
      end
    end
  end

  // Per-cycle compare, plus logs used by the directed literal checks.
  int ren_log[$], done_log[$];
  logic [DW-1:0] got[$];
  always begin
    @(negedge clk);
    if (rst_n) begin
      chk("fifo_ren", 32'(fifo_ren), 32'(cyc == ren_at));
      chk("done", 32'(done), 32'(cyc == done_at));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("remaining", 32'(remaining), 32'(m_rem));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) chk("out_data", 32'(out_data), 32'(exp_data));
      if (fifo_ren) ren_log.push_back(cyc);
      if (done) done_log.push_back(cyc);
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    wen = 1'b1;
    din = b;
    step();
    wen = 1'b0;
  endtask

  task automatic go(input int l, output int s);
    s     = cyc;
    start = 1'b1;
    len   = LEN_W'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n0 = done_log.size();
    int k  = 0;
    while (done_log.size() == n0 && k < maxc) begin
      step();
      k++;
    end
    if (done_log.size() == n0) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic chk_got(input string name, input int g0, input logic [DW-1:0] exp[$]);
    chk({name, "_count"}, 32'(got.size() - g0), 32'(exp.size()));
    foreach (exp[i])
      if (g0 + i < got.size()) chk(name, 32'(got[g0+i]), 32'(exp[i]));
  endtask

  initial begin
    int s, r0, g0;
    repeat (3) @(negedge clk);
    chk("rst_fifo_ren", 32'(fifo_ren), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_underflow", 32'(underflow), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Three preloaded bytes, ready tied high
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    r0 = ren_log.size(); g0 = got.size();
    go(3, s);
    wait_done(40);
    chk_got("t1_data", g0, '{8'h11, 8'h22, 8'h33});
    chk("t1_ren_count", 32'(ren_log.size() - r0), 3);
    if (ren_log.size() - r0 == 3) begin
      chk("t1_first_ren", 32'(ren_log[r0]), 32'(s + 1));
      chk("t1_ren_gap0", 32'(ren_log[r0+1] - ren_log[r0]), 3);
      chk("t1_ren_gap1", 32'(ren_log[r0+2] - ren_log[r0+1]), 3);
    end
    step();
    chk("t1_underflow", 32'(underflow), 0);

    // Empty FIFO: error, backoff retry, late byte
    r0 = ren_log.size(); g0 = got.size();
    go(1, s);
    repeat (4) step();
    push(8'hA5);
    wait_done(40);
    chk_got("t2_data", g0, '{8'hA5});
    chk("t2_ren_count", 32'(ren_log.size() - r0), 2);
    if (ren_log.size() - r0 == 2)
      chk("t2_retry_gap", 32'(ren_log[r0+1] - ren_log[r0]), BACKOFF + 2);
    repeat (3) step();
    chk("t2_uf_sticky", 32'(underflow), 1);

    // Downstream stall on the first byte
    out_ready = 1'b0;
    push(8'h01); push(8'h02);
    r0 = ren_log.size(); g0 = got.size();
    go(2, s);
    repeat (6) step();
    chk("t3_ren_during_stall", 32'(ren_log.size() - r0), 1);
    chk("t3_held_data", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    wait_done(40);
    chk_got("t3_data", g0, '{8'h01, 8'h02});

    // Zero-length burst, then start pulses while busy
    r0 = ren_log.size();
    go(0, s);
    step();
    chk("t4_done_cycle", 32'(done_log[$]), 32'(s + 1));
    chk("t4_no_ren", 32'(ren_log.size() - r0), 0);
    push(8'h44); push(8'h55);
    r0 = ren_log.size(); g0 = got.size();
    go(2, s);
    start = 1'b1; len = 4'd9;
    step(); step();
    start = 1'b0;
    wait_done(40);
    chk_got("t4_data", g0, '{8'h44, 8'h55});
    chk("t4_ren_count", 32'(ren_log.size() - r0), 2);

    // Reset asserted during WAIT of a len=5 burst
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    go(5, s);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ren", 32'(fifo_ren), 0);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_remaining", 32'(remaining), 0);
    chk("t5_underflow", 32'(underflow), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    g0 = got.size();
    go(4, s);
    wait_done(40);
    chk_got("t5_data", g0, '{8'h51, 8'h52, 8'h53, 8'h54});

    // Full FIFO, len=8
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    g0 = got.size();
    go(8, s);
    wait_done(60);
    chk_got("t6_data", g0, '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87});
    chk("t6_fifo_empty", 32'(fq.size()), 0);
    chk("t6_underflow", 32'(underflow), 0);

    // Randomized traffic; writes avoid the ren cycle
    for (int k = 0; k < 1500; k++) begin
      start     = ($urandom_range(7) == 0);
      len       = LEN_W'($urandom_range(15));
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0 && fq.size() < 7 && ren_at != cyc) begin
        wen = 1'b1;
        din = DW'($urandom);
      end else wen = 1'b0;
      step();
    end
    start = 1'b0; out_ready = 1'b1; wen = 1'b0;
    for (int k = 0; k < 600 && (m_busy || done_at >= cyc); k++) begin
      if (fq.size() < 7 && ren_at != cyc) begin
        wen = 1'b1;
        din = DW'($urandom);
      end else wen = 1'b0;
      step();
    end
    wen = 1'b0;
    if (m_busy) chk("flush_timeout", 32'(0), 32'(1));
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
